rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Write-side initiator for the 32x32 MIPS register file: merges writeback requests from the main pipeline (port A) and the long-latency unit (port B: loads, mul/div) onto the file's single write port. Port B goes through a small FIFO. Fixed A priority, plus a starvation guard that forces B through. Sits between the WB stage / long-latency unit and the register file's rf_wen/rf_addr_w/rf_data_w inputs.

Parameters:
B_DEPTH, 4, port-B FIFO entries; power of 2, >=2.
STARVE_LIMIT, 8, consecutive cycles B may be held off while non-empty before a forced B grant; >=1.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, synchronous, active-low
a_valid  input  1  pipeline write request
a_ready  output  1  A accepted when a_valid & a_ready
a_addr  input  5  A destination register
a_data  input  32  A write data
b_valid  input  1  long-latency write request
b_ready  output  1  B accepted when b_valid & b_ready
b_addr  input  5  B destination register
b_data  input  32  B write data
rf_wen  output  1  register-file write enable (registered)
rf_addr_w  output  5  register-file write address (registered)
rf_data_w  output  32  register-file write data (registered)
b_level  output  clog2(B_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rst_n=0 at clk edge): FIFO emptied (queued writes discarded), starve_cnt=0, rf_wen=0, rf_addr_w=0, rf_data_w=0, b_level=0. Applies mid-operation. a_ready=1 and b_ready=1 once reset is released.
- b_ready = !full. No push on a full FIFO, even if a pop happens in the same cycle. Push and pop in the same cycle on a non-full, non-empty FIFO are both allowed; b_level is unchanged.
- force_b = (starve_cnt == STARVE_LIMIT) && !empty. a_ready = !force_b (combinational from state only, not from a_valid).
- Grant, evaluated each cycle in priority order:
  - force_b: pop B.
  - else a_valid: take A.
  - else !empty: pop B.
  - else idle.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) when A is granted and the FIFO is non-empty.
  - Cleared to 0 when B is granted or the FIFO is empty.
  - Unchanged otherwise.
- Output register, updated every edge:
  - rf_wen <= granted && addr != 0.
  - rf_addr_w/rf_data_w <= granted entry's addr/data when rf_wen will be 1, else 0.
  - Idle cycles therefore drive address 0 / data 0 with rf_wen=0.
- Register $0: the request is accepted (handshake completes, FIFO entry consumed) but dropped; rf_wen stays 0.
- Latency:
  - A accepted in cycle t -> rf_wen=1 in cycle t+1.
  - B always passes through the FIFO. B pushed in cycle t can pop no earlier than t+1, so rf_wen=1 no earlier than cycle t+2.
- Ordering: B writes leave in FIFO order. No ordering is guaranteed between A and B; the issue logic must not create WAW between them (see optional feature).
- Throughput: one register-file write per cycle maximum; no bubbles while any request is available.

Optional Feature:
Macro RF_WB_PENDING_EN.
- Defined: adds ports q1_addr input 5, q1_pending output 1, q2_addr input 5, q2_pending output 1, matching the register file's two read ports.
- qN_pending is combinational. It is 1 iff qN_addr != 0 and qN_addr matches a valid FIFO entry or the output register (rf_wen=1, rf_addr_w).
- Hazard logic uses these bits to stall readers of registers not yet written.
- Undefined: these ports and their compare logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, A only: a_valid=1, a_addr=5, a_data=0x1234 in cycle 1 -> rf_wen=1, rf_addr_w=5, rf_data_w=0x1234 in cycle 2; cycle 3 idle -> rf_wen=0, addr=0, data=0.
- B only, FIFO order: push (3,0xA), (4,0xB), (6,0xC) in consecutive cycles with A idle -> writes to 3, 4, 6 in order, first write 2 cycles after first push; b_level returns to 0.
- Full/backpressure: hold a_valid=1 continuously, push 4 B entries -> b_ready=0 after the 4th push; a 5th request stalls until a pop; b_level never exceeds 4.
- Starvation: FIFO holds 1 entry, a_valid held 1 -> after 8 A grants, a_ready=0 for exactly one cycle, the B entry is written, starve_cnt=0, then a_ready=1.
- $0 filter: A write (0,0xFFFF) and B write (0,0x1) -> both handshakes complete, rf_wen never asserted, B entry consumed.
- Reset mid-operation: 3 entries queued and rf_wen=1, then rst_n=0 for one edge -> all outputs 0, b_level=0, no queued write ever appears. With RF_WB_PENDING_EN defined: q1_addr=4 while (4,x) is queued -> q1_pending=1; q1_pending=0 once the write to 4 has issued.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module  : rf_wb_arbiter
// Purpose : Register-file write-port arbiter. Pipeline port A has fixed
//           priority. Long-latency port B is queued through a FIFO, and a
//           starvation guard forces a B grant after it has been held off.
// Options : RF_WB_PENDING_EN adds pending-write lookups for the two read ports
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
  parameter int B_DEPTH      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [4:0]                     a_addr,
  input  logic [31:0]                    a_data,
  input  logic                           b_valid,
  output logic                           b_ready,
  input  logic [4:0]                     b_addr,
  input  logic [31:0]                    b_data,
  output logic                           rf_wen,
  output logic [4:0]                     rf_addr_w,
  output logic [31:0]                    rf_data_w,
`ifdef RF_WB_PENDING_EN
  input  logic [4:0]                     q1_addr,
  output logic                           q1_pending,
  input  logic [4:0]                     q2_addr,
  output logic                           q2_pending,
`endif
  output logic [$clog2(B_DEPTH+1)-1:0]   b_level
);

  localparam int AW = $clog2(B_DEPTH);
  localparam int LW = $clog2(B_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [LW-1:0] C_FULL  = LW'(B_DEPTH);
  localparam logic [SW-1:0] C_LIMIT = SW'(STARVE_LIMIT);

  logic [4:0]    addr_mem_q [B_DEPTH];
  logic [31:0]   data_mem_q [B_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          empty, full, force_b, grant_a, grant_b, push, pop;
  logic [4:0]    sel_addr;
  logic [31:0]   sel_data;
  logic          wen_d;

  assign empty   = (count_q == '0);
  assign full    = (count_q == C_FULL);
  assign force_b = (starve_q == C_LIMIT) && !empty;

  assign a_ready = !force_b;
  assign b_ready = !full;
  assign b_level = count_q;

  // Pop only reads the current head, so an entry pushed this cycle leaves next cycle at the earliest
  assign grant_b = force_b || (!a_valid && !empty);
  assign grant_a = !force_b && a_valid;
  assign pop     = grant_b;
  assign push    = b_valid && !full;

  assign sel_addr = grant_b ? addr_mem_q[rd_ptr_q] : a_addr;
  assign sel_data = grant_b ? data_mem_q[rd_ptr_q] : a_data;
  assign wen_d    = (grant_a || grant_b) && (sel_addr != 5'd0);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (grant_b || empty) begin
      starve_d = '0;
    end else if (grant_a && (starve_q != C_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= b_addr;
      data_mem_q[wr_ptr_q] <= b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      rf_wen    <= 1'b0;
      rf_addr_w <= 5'd0;
      rf_data_w <= 32'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      starve_q  <= starve_d;
      rf_wen    <= wen_d;
      rf_addr_w <= wen_d ? sel_addr : 5'd0;
      rf_data_w <= wen_d ? sel_data : 32'd0;
    end
  end

`ifdef RF_WB_PENDING_EN
  logic [B_DEPTH-1:0] hit1, hit2;

  // A slot is live when its distance from the read pointer is below the occupancy
  for (genvar i = 0; i < B_DEPTH; i++) begin : g_pend
    logic [AW-1:0] offset;
    logic          live;
    assign offset  = AW'(i) - rd_ptr_q;
    assign live    = (LW'(offset) < count_q);
    assign hit1[i] = live && (addr_mem_q[i] == q1_addr);
    assign hit2[i] = live && (addr_mem_q[i] == q2_addr);
  end

  assign q1_pending = (q1_addr != 5'd0) && ((|hit1) || (rf_wen && (rf_addr_w == q1_addr)));
  assign q2_pending = (q2_addr != 5'd0) && ((|hit2) || (rf_wen && (rf_addr_w == q2_addr)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// Module  : tb_rf_wb_arbiter
// Purpose : Self-checking bench for rf_wb_arbiter (vector table, reference
//           model with output scoreboard, directed corner sequences)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;

  localparam int B_DEPTH      = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int LW           = $clog2(B_DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [4:0]    a_addr, b_addr;
  logic [31:0]   a_data, b_data;
  logic          rf_wen;
  logic [4:0]    rf_addr_w;
  logic [31:0]   rf_data_w;
  logic [LW-1:0] b_level;
`ifdef RF_WB_PENDING_EN
  logic [4:0]    q1_addr, q2_addr;
  logic          q1_pending, q2_pending;
`endif

  rf_wb_arbiter #(.B_DEPTH(B_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .rf_wen    (rf_wen),
    .rf_addr_w (rf_addr_w),
    .rf_data_w (rf_data_w),
`ifdef RF_WB_PENDING_EN
    .q1_addr   (q1_addr),
    .q1_pending(q1_pending),
    .q2_addr   (q2_addr),
    .q2_pending(q2_pending),
`endif
    .b_level   (b_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } rfo_t;

  typedef struct {
    logic          av;
    logic [4:0]    aa;
    logic [31:0]   ad;
    logic          bv;
    logic [4:0]    ba;
    logic [31:0]   bd;
    logic          e_ar;
    logic          e_br;
    logic [LW-1:0] e_lvl;
    logic          e_wen;
    logic [4:0]    e_addr;
    logic [31:0]   e_data;
  } vec_t;

  ent_t mq[$];
  rfo_t sb[$];
  int   m_starve = 0;

  logic          d_ar, d_br, d_wen;
  logic [LW-1:0] d_lvl;
  logic [4:0]    d_addr;
  logic [31:0]   d_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check handshake outputs mid-cycle, advance the model, check registered outputs
  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      output logic s_ar, output logic s_br, output logic [LW-1:0] s_lvl,
                      output logic s_wen, output logic [4:0] s_addr, output logic [31:0] s_data);
    logic empty, full, frc, ga, gb;
    ent_t sel, n;
    rfo_t e, got;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    @(negedge clk);
    empty = (mq.size() == 0);
    full  = (mq.size() == B_DEPTH);
    frc   = (m_starve == STARVE_LIMIT) && !empty;
    s_ar = a_ready; s_br = b_ready; s_lvl = b_level;
    chk("a_ready", 32'(a_ready), 32'(!frc));
    chk("b_ready", 32'(b_ready), 32'(!full));
    chk("b_level", 32'(b_level), 32'(mq.size()));
    gb = frc || (!av && !empty);
    ga = !frc && av;
    if (gb) sel = mq[0];
    else begin sel.addr = aa; sel.data = ad; end
    e.wen  = (ga || gb) && (sel.addr != 5'd0);
    e.addr = e.wen ? sel.addr : 5'd0;
    e.data = e.wen ? sel.data : 32'd0;
    sb.push_back(e);
    if (gb) void'(mq.pop_front());
    if (bv && !full) begin n.addr = ba; n.data = bd; mq.push_back(n); end
    if (gb || empty) m_starve = 0;
    else if (ga && m_starve < STARVE_LIMIT) m_starve++;
    @(posedge clk); #1;
    got = sb.pop_front();
    s_wen = rf_wen; s_addr = rf_addr_w; s_data = rf_data_w;
    chk("rf_wen", 32'(rf_wen), 32'(got.wen));
    chk("rf_addr_w", 32'(rf_addr_w), 32'(got.addr));
    chk("rf_data_w", rf_data_w, got.data);
  endtask

  task automatic run(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                     input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    step(av, aa, ad, bv, ba, bd, d_ar, d_br, d_lvl, d_wen, d_addr, d_data);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
    @(posedge clk); #1;
    chk("rst_wen", 32'(rf_wen), 32'd0);
    chk("rst_addr", 32'(rf_addr_w), 32'd0);
    chk("rst_data", rf_data_w, 32'd0);
    chk("rst_level", 32'(b_level), 32'd0);
    rst_n = 1'b1;
    mq.delete();
    sb.delete();
    m_starve = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [13];
    int   n_low, low_idx, max_lvl, wen_seen;
    logic saw_full;

`ifdef RF_WB_PENDING_EN
    q1_addr = 5'd0;
    q2_addr = 5'd0;
`endif
    tbl[0]  = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b1, 5'd5, 32'h1234};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'hA, 1'b1, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd4, 32'hB, 1'b1, 1'b1, 3'd1, 1'b1, 5'd3, 32'hA};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd6, 32'hC, 1'b1, 1'b1, 3'd1, 1'b1, 5'd4, 32'hB};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd1, 1'b1, 5'd6, 32'hC};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0};
    tbl[7]  = '{1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'h1, 1'b1, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd1, 1'b0, 5'd0, 32'h0};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0};
    tbl[10] = '{1'b1, 5'd7, 32'h77,   1'b1, 5'd8, 32'h88, 1'b1, 1'b1, 3'd0, 1'b1, 5'd7, 32'h77};
    tbl[11] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd1, 1'b1, 5'd8, 32'h88};
    tbl[12] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0};

    do_reset();
    do_reset();

    // Directed table: A-only latency, B FIFO order, $0 filtering, A priority
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd,
           d_ar, d_br, d_lvl, d_wen, d_addr, d_data);
      chk($sformatf("tbl%0d_ar", i), 32'(d_ar), 32'(tbl[i].e_ar));
      chk($sformatf("tbl%0d_br", i), 32'(d_br), 32'(tbl[i].e_br));
      chk($sformatf("tbl%0d_lvl", i), 32'(d_lvl), 32'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_wen", i), 32'(d_wen), 32'(tbl[i].e_wen));
      chk($sformatf("tbl%0d_addr", i), 32'(d_addr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_data", i), d_data, tbl[i].e_data);
    end

    // Backpressure: A held busy while B keeps pushing
    do_reset();
    saw_full = 1'b0;
    max_lvl  = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 5'(1 + i), 32'(100 + i), 1'b1, 5'(16 + i), 32'(200 + i),
           d_ar, d_br, d_lvl, d_wen, d_addr, d_data);
      if (!d_br) saw_full = 1'b1;
      if (int'(d_lvl) > max_lvl) max_lvl = int'(d_lvl);
    end
    chk("bp_full_seen", 32'(saw_full), 32'd1);
    chk("bp_max_level", 32'(max_lvl), 32'd4);

    // Starvation: one queued B entry against continuous A traffic
    do_reset();
    n_low   = 0;
    low_idx = -1;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 5'd2, 32'(i), (i == 0), 5'd9, 32'h9999,
           d_ar, d_br, d_lvl, d_wen, d_addr, d_data);
      if (!d_ar) begin
        n_low++;
        low_idx = i;
        chk("starve_b_addr", 32'(d_addr), 32'd9);
        chk("starve_b_data", d_data, 32'h9999);
      end
    end
    chk("starve_low_cycles", 32'(n_low), 32'd1);
    chk("starve_low_index", 32'(low_idx), 32'd9);
    chk("starve_fifo_empty", 32'(b_level), 32'd0);

    // Reset in mid-operation discards queued writes
    do_reset();
    for (int i = 0; i < 3; i++) run(1'b1, 5'(1 + i), 32'(50 + i), 1'b1, 5'(20 + i), 32'(60 + i));
    chk("mid_wen_before", 32'(rf_wen), 32'd1);
    chk("mid_level_before", 32'(b_level), 32'd3);
    do_reset();
    wen_seen = 0;
    for (int i = 0; i < 6; i++) begin
      run(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      if (rf_wen) wen_seen++;
    end
    chk("mid_no_stale_write", 32'(wen_seen), 32'd0);

`ifdef RF_WB_PENDING_EN
    do_reset();
    q1_addr = 5'd4;
    q2_addr = 5'd0;
    run(1'b1, 5'd9, 32'h9, 1'b1, 5'd4, 32'h44);
    chk("pend_queued", 32'(q1_pending), 32'd1);
    chk("pend_zero_addr", 32'(q2_pending), 32'd0);
    run(1'b1, 5'd10, 32'hA, 1'b0, 5'd0, 32'd0);
    chk("pend_still_queued", 32'(q1_pending), 32'd1);
    run(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("pend_in_outreg", 32'(q1_pending), 32'd1);
    run(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("pend_cleared", 32'(q1_pending), 32'd0);
    q1_addr = 5'd0;
`endif

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      run(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
